// File: rtl/tnew_hazard_ctrl.sv
// Producer-side hazard controller for a 5-stage MIPS pipeline.
// Each instruction leaving D leaves a {dest, Tnew} record. The records age
// through E, M and W and are compared against the Tuse demand of the
// instruction now in D. The block also tracks the multiply/divide busy window.
// It produces the global D-stage stall and the D-stage forwarding selects.
module tnew_hazard_ctrl #(
    parameter logic [3:0] MULT_CYC = 4'd5,
    parameter logic [3:0] DIV_CYC  = 4'd10,
    parameter logic [2:0] NOTUSE   = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [2:0] d_tuse_rs,
    input  logic [2:0] d_tuse_rt,
    input  logic [4:0] d_waddr,
    input  logic [2:0] d_tnew,
    input  logic [1:0] d_md_start,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic [4:0] e_waddr,
    output logic [4:0] m_waddr,
    output logic [4:0] w_waddr,
    output logic       md_busy
);

    logic [4:0] e_addr_q, m_addr_q, w_addr_q;
    logic [4:0] e_addr_d, m_addr_d, w_addr_d;
    logic [2:0] e_tnew_q, m_tnew_q, w_tnew_q;
    logic [2:0] e_tnew_d, m_tnew_d, w_tnew_d;
    logic [3:0] busy_cnt_q, busy_cnt_d;

    // Tnew counts down once per stage and never goes below zero.
    function automatic logic [2:0] dec3(input logic [2:0] x);
        return (x != 3'd0) ? (x - 3'd1) : 3'd0;
    endfunction

    // Operand 0 is rs, operand 1 is rt; both use the same hazard and forwarding logic.
    logic [4:0] src  [2];
    logic [2:0] tuse [2];
    logic [1:0] hz;
    logic [3:0] sel_flat;

    assign src[0]  = d_rs;
    assign src[1]  = d_rt;
    assign tuse[0] = d_tuse_rs;
    assign tuse[1] = d_tuse_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic e_hit, m_hit, w_hit;
            assign e_hit = (src[gi] != 5'd0) && (e_addr_q == src[gi]);
            assign m_hit = (src[gi] != 5'd0) && (m_addr_q == src[gi]);
            assign w_hit = (src[gi] != 5'd0) && (w_addr_q == src[gi]);

            // A producer in E or M whose result is later than the consumer needs it causes a stall.
            assign hz[gi] = (tuse[gi] != NOTUSE) &&
                            ((e_hit && (e_tnew_q > tuse[gi])) ||
                             (m_hit && (m_tnew_q > tuse[gi])));

            // The youngest match decides. If its value is not ready yet, read the regfile
            // (the stall covers it) rather than falling back to an older, stale stage.
            assign sel_flat[gi*2 +: 2] =
                e_hit ? ((e_tnew_q == 3'd0) ? 2'b01 : 2'b00) :
                m_hit ? ((m_tnew_q == 3'd0) ? 2'b10 : 2'b00) :
                w_hit ? ((w_tnew_q == 3'd0) ? 2'b11 : 2'b00) :
                        2'b00;
        end
    endgenerate

    logic md_stall;
    assign md_stall   = d_md_use && (busy_cnt_q != 4'd0);
    assign stall      = hz[0] | hz[1] | md_stall;
    assign fwd_rs_sel = sel_flat[1:0];
    assign fwd_rt_sel = sel_flat[3:2];
    assign e_waddr    = e_addr_q;
    assign m_waddr    = m_addr_q;
    assign w_waddr    = w_addr_q;
    assign md_busy    = (busy_cnt_q != 4'd0);

    // Next-state selection: flush wipes the pipeline, stall injects a bubble into E, otherwise D enters E.
    always_comb begin
        m_addr_d   = e_addr_q;
        m_tnew_d   = dec3(e_tnew_q);
        w_addr_d   = m_addr_q;
        w_tnew_d   = dec3(m_tnew_q);
        e_addr_d   = stall ? 5'd0 : d_waddr;
        e_tnew_d   = stall ? 3'd0 : d_tnew;
        busy_cnt_d = (busy_cnt_q != 4'd0) ? (busy_cnt_q - 4'd1) : 4'd0;
        if (flush) begin
            e_addr_d = 5'd0;
            e_tnew_d = 3'd0;
            m_addr_d = 5'd0;
            m_tnew_d = 3'd0;
            w_addr_d = 5'd0;
            w_tnew_d = 3'd0;
        end else if (!stall) begin
            // A new mult/div only launches on an edge where it really leaves D.
            if (d_md_start == 2'b01) begin
                busy_cnt_d = MULT_CYC;
            end else if (d_md_start == 2'b10) begin
                busy_cnt_d = DIV_CYC;
            end
        end
    end

    // Stage records and busy counter; the active-low reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_addr_q   <= 5'd0;
            e_tnew_q   <= 3'd0;
            m_addr_q   <= 5'd0;
            m_tnew_q   <= 3'd0;
            w_addr_q   <= 5'd0;
            w_tnew_q   <= 3'd0;
            busy_cnt_q <= 4'd0;
        end else begin
            e_addr_q   <= e_addr_d;
            e_tnew_q   <= e_tnew_d;
            m_addr_q   <= m_addr_d;
            m_tnew_q   <= m_tnew_d;
            w_addr_q   <= w_addr_d;
            w_tnew_q   <= w_tnew_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

endmodule
